// File: rtl/lab3_sweep_ctrl.sv
// Self-test sequencer for the lab3 gate network: walks codes 0..7 on {a,b,c}, samples x/y after
// a settle delay, and records the mismatch count plus the first failing vector.
module lab3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       x_in,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic       fail_vld,
    output logic [2:0] fail_code,
    output logic [1:0] fail_xy
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e     state;
    logic [2:0] code;
    logic [3:0] cnt;
    logic       x_exp;
    logic       y_exp;
    logic       mismatch;
    logic [3:0] err_nxt;

    always_comb begin
        x_exp    = ~(code[2] ^ code[1]);
        y_exp    = (code[2] | code[1]) & code[0];
        mismatch = (x_in != x_exp) || (y_in != y_exp);
        err_nxt  = err_cnt + {3'b000, mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= StIdle;
            code                  <= 3'd0;
            cnt                   <= 4'd0;
            {a_out, b_out, c_out} <= 3'd0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            pass                  <= 1'b0;
            err_cnt               <= 4'd0;
            fail_vld              <= 1'b0;
            fail_code             <= 3'd0;
            fail_xy               <= 2'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !abort) begin
                        state                 <= StSettle;
                        code                  <= 3'd0;
                        cnt                   <= 4'd0;
                        {a_out, b_out, c_out} <= 3'd0;
                        busy                  <= 1'b1;
                        pass                  <= 1'b0;
                        err_cnt               <= 4'd0;
                        fail_vld              <= 1'b0;
                        fail_code             <= 3'd0;
                        fail_xy               <= 2'd0;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        state                 <= StIdle;
                        busy                  <= 1'b0;
                        pass                  <= 1'b0;
                        {a_out, b_out, c_out} <= 3'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'(SETTLE_CYC - 1)) begin
                            state <= StSample;
                        end
                    end
                end
                StSample: begin
                    // Abort takes priority: a mismatch seen in the aborted cycle is dropped.
                    if (abort) begin
                        state                 <= StIdle;
                        busy                  <= 1'b0;
                        pass                  <= 1'b0;
                        {a_out, b_out, c_out} <= 3'd0;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_nxt;
                            if (!fail_vld) begin
                                fail_vld  <= 1'b1;
                                fail_code <= code;
                                fail_xy   <= {x_in, y_in};
                            end
                        end
                        if (code == 3'd7) begin
                            state                 <= StDone;
                            done                  <= 1'b1;
                            busy                  <= 1'b0;
                            pass                  <= (err_nxt == 4'd0);
                            {a_out, b_out, c_out} <= 3'd0;
                        end else begin
                            state                 <= StSettle;
                            code                  <= code + 3'd1;
                            cnt                   <= 4'd0;
                            {a_out, b_out, c_out} <= code + 3'd1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/lab3_sweep_ctrl.md
Name: lab3_sweep_ctrl

Overview:
- Sequencer that drives the lab3 gate network exhaustively through all 8 input codes.
- After a programmable settle time it samples the network's x/y outputs and checks them against a built-in golden model.
- Accumulates the mismatch count and the first failing vector.
- Sits beside the lab3 instance as its self-test/bring-up controller: owns the a/b/c drive and reads back x/y.

Parameters:
- SETTLE_CYC, 2, cycles a code is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- abort  in  1  cancels a running sweep
- x_in  in  1  x output of the lab3 network
- y_in  in  1  y output of the lab3 network
- a_out  out  1  drives lab3 input a (code bit 2)
- b_out  out  1  drives lab3 input b (code bit 1)
- c_out  out  1  drives lab3 input c (code bit 0)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when a sweep completes normally
- pass  out  1  last completed sweep had zero mismatches; held until next start
- err_cnt  out  4  mismatches in last sweep, 0..8
- fail_vld  out  1  at least one mismatch recorded
- fail_code  out  3  {a,b,c} of the first mismatch
- fail_xy  out  2  {x_in,y_in} captured at the first mismatch

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: every output 0; state IDLE; code 0; settle counter 0. Reset mid-sweep abandons the sweep without a done pulse.
- Golden model, for code {a,b,c}:
  - x_exp = ~(a ^ b)
  - y_exp = (a | b) & c
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - a/b/c outputs are 0.
  - start=1 and abort=0: next cycle enters SETTLE with code=0 and cnt=0. busy=1, err_cnt=0, fail_vld=0, fail_code=0, fail_xy=0, pass=0.
- SETTLE:
  - a/b/c outputs equal code.
  - cnt increments each cycle. After exactly SETTLE_CYC cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle):
  - Compare x_in/y_in against golden for the current code.
  - On mismatch: err_cnt increments.
  - On mismatch with fail_vld=0: capture fail_code=code, fail_xy={x_in,y_in}, and set fail_vld=1.
  - If code==7: go to DONE. Otherwise code+1, cnt=0, return to SETTLE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass = (err_cnt==0), evaluated after including the final sample.
  - a/b/c outputs return to 0. Next state is IDLE.
- Latency:
  - Each code takes SETTLE_CYC+1 cycles.
  - With start sampled at edge 0, done is high in cycle 1 + 8*(SETTLE_CYC+1). For SETTLE_CYC=2 that is cycle 25.
- start while busy or while in DONE: ignored; no restart or queuing.
- abort:
  - abort=1 in SETTLE or SAMPLE: next cycle IDLE, busy=0, a/b/c=0, no done pulse, pass=0.
  - err_cnt and fail_* keep their partial values.
  - abort in the same SAMPLE cycle as a mismatch: abort wins and the mismatch is not counted.
- abort and start together in IDLE: abort wins; stays IDLE.
- Code counter never wraps: the sweep ends after code 7.
- err_cnt saturation is unnecessary; its maximum is 8.

Test Plan:
- Healthy network, SETTLE_CYC=2; start pulse at cycle 0 → done high only in cycle 25; pass=1, err_cnt=0, fail_vld=0. Sequence {a,b,c}=000..111 each held 3 cycles.
- Model x stuck-at-0 → err_cnt=4 (codes 0,1,6,7), fail_code=3'b000, fail_xy=2'b00, pass=0.
- Model y stuck-at-1 → err_cnt=5 (codes 0,2,4,6 plus code 1), fail_code=3'b000, fail_xy=2'b11.
- Abort asserted during code 3 SETTLE → busy drops next cycle, a/b/c=000, done never pulses, pass=0. A following start runs a full clean sweep with pass=1.
- start pulsed again at cycles 5 and 10 of a running sweep → no effect; done still at cycle 25. rst asserted at cycle 12 → all outputs 0 next cycle, no done.
- SETTLE_CYC=1 → done at cycle 17; x_in/y_in changing only in settle cycles never affect the result.
